samp_packetizer: RTL
====================

SAMP_PACKETIZER -- requirements
Module: samp_packetizer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, sample bus width; only 32 or 64 legal.
REQ-002 SHALL have parameter SEQ_INIT, default 0, 12-bit seqnum value after reset or clear.
REQ-003 SHALL have ports: clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: i_tdata  in  WIDTH  sample; i_teob  in  1  end-of-burst on this sample; i_tvalid  in  1; i_tready  out  1.
REQ-006 SHALL have ports: o_tdata  out  WIDTH; o_tuser  out  128  header for framer; o_tlast  out  1; o_tvalid  out  1; o_tready  in  1.
REQ-007 SHALL have ports: cfg_spp  in  16  samples per packet; cfg_sid  in  32  stream ID; cfg_has_time  in  1  timestamp enable.
REQ-008 SHALL have ports: cfg_time  in  64  time load value; cfg_time_load  in  1  one-cycle load strobe; cfg_seq_clr  in  1  one-cycle seqnum clear strobe.

Function
REQ-009 SHALL cut the input sample stream into packets and emit each sample with o_tuser/o_tlast suitable for the downstream CHDR framer.
REQ-010 SHALL use one output register stage: i_tready = ~o_tvalid | o_tready; accepted sample appears on o_* the next cycle (latency 1); no combinational path from i_tvalid to o_tvalid.
REQ-011 SHALL hold o_tdata/o_tuser/o_tlast stable while o_tvalid=1 and o_tready=0.
REQ-012 SHALL have two states: IDLE (no packet open) and BODY (packet open); IDLE->BODY on first accepted sample unless it also ends the packet; BODY->IDLE on accepted sample that ends the packet.
REQ-013 SHALL latch cfg_spp, cfg_sid, cfg_has_time on the first accepted sample of a packet; mid-packet cfg changes take effect next packet.
REQ-014 SHALL treat latched spp=0 as spp=1.
REQ-015 SHALL keep a 16-bit sample count reset to 0 at packet start; a sample ends the packet when count = spp-1 or i_teob=1; that sample is output with o_tlast=1.
REQ-016 SHALL drive o_tuser: [127:126]=2'b00; [125]=latched has_time; [124]=eob (1 only on tlast beat of a packet ended by i_teob); [123:112]=seqnum; [111:96]=payload bytes = (count+1)*WIDTH/8, mod 2^16; [95:64]=latched sid; [63:0]=packet start time.
REQ-017 SHALL guarantee all o_tuser fields valid on the o_tlast beat; fields other than [124] and [111:96] constant across the packet.
REQ-018 SHALL increment 12-bit seqnum after each packet's last sample is accepted; 4095 wraps to 0.
REQ-019 SHALL on cfg_seq_clr set seqnum to SEQ_INIT; if coincident with a packet end, clear wins; an open packet keeps its latched seqnum.
REQ-020 SHALL keep a 64-bit time counter; at packet end it adds the packet's sample count (count+1), wrapping mod 2^64.
REQ-021 SHALL on cfg_time_load set the time counter to cfg_time; load wins over a coincident packet-end increment; affects only packets not yet started.
REQ-022 SHALL latch packet start time from the time counter on first sample; the time counter advances regardless of cfg_has_time.
REQ-023 SHALL not drop, duplicate, or reorder samples under any o_tready pattern.

Reset
REQ-024 SHALL on rst_n=0 immediately force: o_tvalid=0, o_tlast=0, o_tdata=0, o_tuser=0, state IDLE, count=0, seqnum=SEQ_INIT, time=0; i_tready=1 after reset release.
REQ-025 SHALL on reset mid-packet discard the open packet; first sample after release starts a new packet with seqnum=SEQ_INIT.

Verification
REQ-026 SHALL cover: WIDTH=32, spp=4, has_time=1, time loaded 1000, 12 samples, o_tready=1 -> 3 packets, tlast on samples 4/8/12, seqnum 0,1,2, time 1000,1004,1008, length 16, eob=0.
REQ-027 SHALL cover: spp=8, i_teob on sample 3 -> packet of 3, tlast on sample 3, eob=1, length 12 (WIDTH=32) / 24 (WIDTH=64); next packet time +3.
REQ-028 SHALL cover: 4096+ packets of spp=1 -> seqnum 4095 followed by 0; cfg_seq_clr coincident with packet end -> next seqnum SEQ_INIT.
REQ-029 SHALL cover: random o_tready (50%) with continuous input -> output sequence identical to input, all tuser fields match model, o_* stable while stalled.
REQ-030 SHALL cover: cfg_time_load coincident with packet end (time 5000) -> next packet time 5000; cfg_spp changed mid-packet -> current packet length unchanged.
REQ-031 SHALL cover: rst_n asserted mid-packet with o_tvalid=1 -> o_tvalid=0 asynchronously; after release first packet seqnum=SEQ_INIT, time=0.

Source files
------------

// File: rtl/samp_packetizer.sv
// Sample packetizer: slices a valid/ready sample stream into packets and
// attaches the CHDR framer header (seqnum, length, stream ID, timestamp).
module samp_packetizer #(
  parameter int          WIDTH    = 32,     // 32 or 64
  parameter logic [11:0] SEQ_INIT = 12'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  i_tdata,
  input  logic              i_teob,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic [WIDTH-1:0]  o_tdata,
  output logic [127:0]      o_tuser,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready,
  input  logic [15:0]       cfg_spp,
  input  logic [31:0]       cfg_sid,
  input  logic              cfg_has_time,
  input  logic [63:0]       cfg_time,
  input  logic              cfg_time_load,
  input  logic              cfg_seq_clr
);

  localparam int BYTES = WIDTH / 8;

  typedef enum logic {IDLE, BODY} state_t;

  state_t        state;
  state_t        state_nxt;

  logic          first;
  logic          vld_p0;
  logic          last_p0;
  logic [127:0]  tuser_p0;

  // Per-packet context, frozen on the first sample of each packet
  logic [15:0]   spp_lat;
  logic [31:0]   sid_lat;
  logic          ht_lat;
  logic [11:0]   seq_lat;
  logic [63:0]   time_lat;

  logic [15:0]   count;
  logic [11:0]   seqnum;
  logic [63:0]   time_cnt;

  logic [15:0]   spp_cur;
  logic [31:0]   sid_cur;
  logic          ht_cur;
  logic [11:0]   seq_cur;
  logic [63:0]   time_cur;
  logic [15:0]   cnt_cur;

  // Index of the final sample in a packet; spp of zero behaves as one.
  function automatic logic [15:0] last_index(input logic [15:0] spp);
    return (spp == 16'd0) ? 16'd0 : spp - 16'd1;
  endfunction

  // Payload length in bytes for a packet holding idx+1 samples, modulo 2^16.
  function automatic logic [15:0] payload_bytes(input logic [15:0] idx);
    logic [31:0] beats;
    beats = {16'd0, idx} + 32'd1;
    return 16'(beats * 32'(BYTES));
  endfunction

  // ---- stage p0: input acceptance and header assembly ----
  assign vld_p0   = i_tvalid & i_tready;

  assign spp_cur  = first ? cfg_spp      : spp_lat;
  assign sid_cur  = first ? cfg_sid      : sid_lat;
  assign ht_cur   = first ? cfg_has_time : ht_lat;
  assign seq_cur  = first ? seqnum       : seq_lat;
  assign time_cur = first ? time_cnt     : time_lat;
  assign cnt_cur  = first ? 16'd0        : count;

  assign last_p0  = (cnt_cur == last_index(spp_cur)) | i_teob;
  assign tuser_p0 = {2'b00, ht_cur, i_teob, seq_cur, payload_bytes(cnt_cur),
                     sid_cur, time_cur};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vld_p0 && !last_p0) state_nxt = BODY;
      BODY:    if (vld_p0 && last_p0)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; the ready path depends only on registered state and o_tready
  always_comb begin
    first    = (state == IDLE);
    i_tready = ~o_tvalid | o_tready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spp_lat  <= 16'd0;
      sid_lat  <= 32'd0;
      ht_lat   <= 1'b0;
      seq_lat  <= 12'd0;
      time_lat <= 64'd0;
    end else if (vld_p0 && first) begin
      spp_lat  <= cfg_spp;
      sid_lat  <= cfg_sid;
      ht_lat   <= cfg_has_time;
      seq_lat  <= seqnum;
      time_lat <= time_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'd0;
    end else if (vld_p0) begin
      count <= last_p0 ? 16'd0 : cnt_cur + 16'd1;
    end
  end

  // Strobes override a coincident packet-end update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seqnum <= SEQ_INIT;
    end else if (cfg_seq_clr) begin
      seqnum <= SEQ_INIT;
    end else if (vld_p0 && last_p0) begin
      seqnum <= seqnum + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_cnt <= 64'd0;
    end else if (cfg_time_load) begin
      time_cnt <= cfg_time;
    end else if (vld_p0 && last_p0) begin
      time_cnt <= time_cnt + {48'd0, cnt_cur} + 64'd1;
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tuser  <= '0;
      o_tlast  <= 1'b0;
    end else if (vld_p0) begin
      o_tvalid <= 1'b1;
      o_tdata  <= i_tdata;
      o_tuser  <= tuser_p0;
      o_tlast  <= last_p0;
    end else if (o_tready) begin
      o_tvalid <= 1'b0;
    end
  end

endmodule
